// File: rtl/clkdiv_pkg.sv
// Shared constants, counter type and divisor clamp for the programmable clock-divider bank.
package clkdiv_pkg;

    localparam int CNT_W_DEF       = 32;
    localparam int DEFAULT_DIV_DEF = 50000000;

    typedef logic [CNT_W_DEF-1:0] cnt_t;

    // Divisors 0 and 1 both mean "tick every cycle".
    function automatic logic [63:0] div_clamp(input logic [63:0] n);
        return (n == 64'd0) ? 64'd1 : n;
    endfunction

endpackage

// File: rtl/clkdiv_chan.sv
// One divider channel: counter, shadow/active divisor, registered tick and 50% clk_div.
// Optional manual stepping when CLKDIV_STEP_EN is defined.
module clkdiv_chan
    import clkdiv_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             ld_i,
    input  logic [CNT_W-1:0] wr_div_i,
`ifdef CLKDIV_STEP_EN
    input  logic             step_mode_i,
    input  logic             step_i,
`endif
    output logic             tick_o,
    output logic             clk_div_o
);

    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] DIV_R = CNT_W'(DEFAULT_DIV);

    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] div_shd_q, div_shd_d;
    logic [CNT_W-1:0] div_act_q, div_act_d;
    logic [CNT_W-1:0] div_eff;
    logic             tick_q, tick_d;
    logic             clk_div_q, clk_div_d;
    logic             terminal;

    // Clamp before subtracting so a zero divisor cannot underflow the compare.
    assign div_eff  = CNT_W'(div_clamp(64'(div_act_q)));
    assign terminal = (count_q == div_eff - ONE);

    always_comb begin
        div_shd_d = ld_i ? wr_div_i : div_shd_q;
        count_d   = count_q;
        div_act_d = div_act_q;
        tick_d    = 1'b0;
        clk_div_d = clk_div_q;
`ifdef CLKDIV_STEP_EN
        if (step_mode_i) begin
            if (ld_i) begin
                div_act_d = wr_div_i;
                count_d   = '0;
            end
            if (en_i && step_i) begin
                tick_d    = 1'b1;
                clk_div_d = ~clk_div_q;
            end
        end else
`endif
        if (!en_i) begin
            if (ld_i) begin
                div_act_d = wr_div_i;
                count_d   = '0;
            end
        end else if (terminal) begin
            count_d   = '0;
            tick_d    = 1'b1;
            clk_div_d = ~clk_div_q;
            div_act_d = div_shd_d;
        end else begin
            count_d   = count_q + ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q   <= '0;
            div_shd_q <= DIV_R;
            div_act_q <= DIV_R;
            tick_q    <= 1'b0;
            clk_div_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            div_shd_q <= div_shd_d;
            div_act_q <= div_act_d;
            tick_q    <= tick_d;
            clk_div_q <= clk_div_d;
        end
    end

    assign tick_o    = tick_q;
    assign clk_div_o = clk_div_q;

endmodule

// File: rtl/prog_clkdiv_bank.sv
// Bank of NUM_CH programmable clock dividers; decodes the divisor write port per channel.
// Optional step_mode/step ports when CLKDIV_STEP_EN is defined.
module prog_clkdiv_bank
    import clkdiv_pkg::*;
#(
    parameter int  NUM_CH      = 2,
    parameter int  CNT_W       = CNT_W_DEF,
    parameter int  DEFAULT_DIV = DEFAULT_DIV_DEF,
    localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] en,
    input  logic              wr_en,
    input  logic [CH_W-1:0]   wr_ch,
    input  logic [CNT_W-1:0]  wr_div,
`ifdef CLKDIV_STEP_EN
    input  logic              step_mode,
    input  logic              step,
`endif
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] clk_div
);

    logic [NUM_CH-1:0] ld;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        // Out-of-range channel numbers match no channel, so such writes are dropped.
        assign ld[i] = wr_en && (32'(wr_ch) == i);

        clkdiv_chan #(
            .CNT_W       (CNT_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_chan (
            .clk         (clk),
            .rst_n       (rst_n),
            .en_i        (en[i]),
            .ld_i        (ld[i]),
            .wr_div_i    (wr_div),
`ifdef CLKDIV_STEP_EN
            .step_mode_i (step_mode),
            .step_i      (step),
`endif
            .tick_o      (tick[i]),
            .clk_div_o   (clk_div[i])
        );
    end

endmodule
